// File: rtl/muldiv_alu_control.sv
// ALU control decoder with an iterative multiply/divide unit and HI/LO registers.
// Multi-cycle ops take WIDTH+2 cycles from accept to the HI/LO write and hold the pipeline via stall.
module muldiv_alu_control #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       func,
  input  logic             valid,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [3:0]       salida,
  output logic             illegal,
  output logic             stall,
  output logic             md_busy,
  output logic [WIDTH-1:0] mf_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   a_orig;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;

  logic               r_type;
  logic               md_op;
  logic               mfmt_op;
  logic               accept;
  logic               mt_write;
  logic               op_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    salida  = 4'b1111;
    illegal = 1'b0;
    case (ALUOp)
      2'd0: salida = 4'b0010;
      2'd1: salida = 4'b0110;
      2'd2: begin
        case (func)
          6'd32, 6'd33: salida = 4'b0010;
          6'd34, 6'd35: salida = 4'b0110;
          6'd36:        salida = 4'b0000;
          6'd37:        salida = 4'b0001;
          6'd38:        salida = 4'b0011;
          6'd39:        salida = 4'b1100;
          6'd42:        salida = 4'b0111;
          6'd43:        salida = 4'b1000;
          6'd0:         salida = 4'b0100;
          6'd2:         salida = 4'b0101;
          6'd3:         salida = 4'b1001;
          6'd16, 6'd17, 6'd18, 6'd19,
          6'd24, 6'd25, 6'd26, 6'd27: salida = 4'b1111;
          default: begin
            salida  = 4'b1111;
            illegal = valid;
          end
        endcase
      end
      default: salida = 4'b1111;
    endcase
  end

  // func 24..27 share 0110xx, func 16..19 share 0100xx; bit0 = unsigned / move-to, bit1 = div / LO
  assign r_type   = valid && (ALUOp == 2'd2);
  assign md_op    = r_type && (func[5:2] == 4'b0110);
  assign mfmt_op  = r_type && (func[5:2] == 4'b0100);
  assign accept   = md_op && (state == ST_IDLE) && !flush;
  assign mt_write = mfmt_op && func[0] && (state == ST_IDLE) && !flush;

  assign stall   = reset_n && (accept || (state == ST_BUSY) ||
                               (mfmt_op && (state != ST_IDLE)));
  assign md_busy = (state != ST_IDLE);
  assign mf_data = (reset_n && mfmt_op && !func[0] && (state == ST_IDLE)) ?
                   (func[1] ? lo : hi) : '0;

  assign op_signed = !func[0];
  assign a_neg     = op_signed && op_a[WIDTH-1];
  assign b_neg     = op_signed && op_b[WIDTH-1];
  assign a_mag     = a_neg ? -op_a : op_a;
  assign b_mag     = b_neg ? -op_b : op_b;

  assign mul_sum   = {1'b0, acc} + {1'b0, (quo[0] ? dvs : '0)};
  assign div_shift = {acc, quo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, dvs});

  assign prod     = {acc, quo};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -quo : quo;
  assign rem_fix  = neg_r ? -acc : acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      acc      <= '0;
      quo      <= '0;
      dvs      <= '0;
      a_orig   <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_BUSY;
            cnt      <= CNT_W'(WIDTH - 1);
            acc      <= '0;
            quo      <= a_mag;
            dvs      <= b_mag;
            a_orig   <= op_a;
            is_div   <= func[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= func[1] && (op_b == '0);
          end else if (mt_write) begin
            if (func[1]) lo <= op_a;
            else         hi <= op_a;
          end
        end
        ST_BUSY: begin
          // acc:quo is one shift register; multiply shifts right, divide shifts left
          if (is_div) begin
            acc <= div_ge ? (div_shift[WIDTH-1:0] - dvs) : div_shift[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], div_ge};
          end else begin
            acc <= mul_sum[WIDTH:1];
            quo <= {mul_sum[0], quo[WIDTH-1:1]};
          end
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) state <= ST_FIX;
        end
        ST_FIX: begin
          state <= ST_IDLE;
          if (!is_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (div_zero) begin
            hi <= a_orig;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_alu_control.sv
// Directed bench for muldiv_alu_control at WIDTH=32 with hand-computed expectations.
module tb_muldiv_alu_control;

  logic        clk;
  logic        reset_n;
  logic [1:0]  alu_op;
  logic [5:0]  func;
  logic        valid;
  logic        flush;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  salida;
  logic        illegal;
  logic        stall;
  logic        md_busy;
  logic [31:0] mf_data;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_alu_control #(.WIDTH(32), .CNT_W(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ALUOp   (alu_op),
    .func    (func),
    .valid   (valid),
    .flush   (flush),
    .op_a    (op_a),
    .op_b    (op_b),
    .salida  (salida),
    .illegal (illegal),
    .stall   (stall),
    .md_busy (md_busy),
    .mf_data (mf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_salida(input int f);
    case (f)
      32, 33: return 4'b0010;
      34, 35: return 4'b0110;
      36:     return 4'b0000;
      37:     return 4'b0001;
      38:     return 4'b0011;
      39:     return 4'b1100;
      42:     return 4'b0111;
      43:     return 4'b1000;
      0:      return 4'b0100;
      2:      return 4'b0101;
      3:      return 4'b1001;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic exp_illegal(input int f);
    case (f)
      0, 2, 3, 16, 17, 18, 19, 24, 25, 26, 27,
      32, 33, 34, 35, 36, 37, 38, 39, 42, 43: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Issues one md op held valid until the pipeline advances, then reads LO and HI back.
  task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int sc;
    int bc;
    logic stall_now;
    sc = 0;
    bc = 0;
    valid = 1'b1; alu_op = 2'd2; func = f; op_a = a; op_b = b; flush = 1'b0;
    for (int i = 0; i < 80; i++) begin
      #1;
      if (stall) sc++;
      if (md_busy) bc++;
      stall_now = stall;
      step();
      if (!stall_now) break;
    end
    chk({tag, "_stall_cycles"}, 64'(sc), 64'd33);
    chk({tag, "_busy_cycles"}, 64'(bc), 64'd33);
    chk({tag, "_not_reaccepted"}, {63'd0, md_busy}, 64'd0);
    func = 6'd18;
    #1;
    chk({tag, "_mflo_nostall"}, {63'd0, stall}, 64'd0);
    chk({tag, "_lo"}, {32'd0, mf_data}, {32'd0, exp_lo});
    func = 6'd16;
    #1;
    chk({tag, "_hi"}, {32'd0, mf_data}, {32'd0, exp_hi});
    valid = 1'b0;
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    alu_op = 2'd0; func = 6'd0; valid = 1'b0; flush = 1'b0;
    op_a = '0; op_b = '0;
    #1;
    chk("reset_stall", {63'd0, stall}, 64'd0);
    chk("reset_busy", {63'd0, md_busy}, 64'd0);
    chk("reset_mf", {32'd0, mf_data}, 64'd0);
    chk("aluop0", {60'd0, salida}, 64'h2);
    #20;
    reset_n = 1'b1;
    step();

    valid = 1'b1;
    alu_op = 2'd1; #1;
    chk("aluop1", {60'd0, salida}, 64'h6);
    alu_op = 2'd3; #1;
    chk("aluop3", {60'd0, salida}, 64'hF);
    chk("aluop3_illegal", {63'd0, illegal}, 64'd0);

    // flush keeps md/mt ops in the sweep from being accepted at any clock edge
    alu_op = 2'd2; flush = 1'b1;
    for (int f = 0; f < 64; f++) begin
      func = 6'(f);
      #1;
      chk($sformatf("sweep_sal_%0d", f), {60'd0, salida}, {60'd0, exp_salida(f)});
      chk($sformatf("sweep_ill_%0d", f), {63'd0, illegal}, {63'd0, exp_illegal(f)});
    end
    valid = 1'b0; func = 6'd1; #1;
    chk("illegal_needs_valid", {63'd0, illegal}, 64'd0);
    flush = 1'b0;
    step();

    run_md("mult_neg3x7", 6'd24, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_md("multu_max", 6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_md("divu_100_7", 6'd27, 32'd100, 32'd7, 32'd2, 32'd14);
    run_md("div_m7_2", 6'd26, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("divu_5_0", 6'd27, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    run_md("div_m5_0", 6'd26, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run_md("div_minneg_m1", 6'd26, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);

    valid = 1'b1; alu_op = 2'd2; func = 6'd17; op_a = 32'h12345678;
    step();
    func = 6'd19; op_a = 32'hCAFEF00D;
    step();
    func = 6'd16; #1;
    chk("mthi", {32'd0, mf_data}, 64'h12345678);
    func = 6'd18; #1;
    chk("mtlo", {32'd0, mf_data}, 64'hCAFEF00D);

    func = 6'd25; op_a = 32'h0000FFFF; op_b = 32'h00010001; #1;
    chk("flush_accept_stall", {63'd0, stall}, 64'd1);
    step();
    repeat (9) step();
    chk("flush_busy10", {63'd0, md_busy}, 64'd1);
    flush = 1'b1; valid = 1'b0;
    step();
    flush = 1'b0; #1;
    chk("flush_idle", {63'd0, md_busy}, 64'd0);
    chk("flush_stall", {63'd0, stall}, 64'd0);
    valid = 1'b1; func = 6'd16; #1;
    chk("flush_hi_kept", {32'd0, mf_data}, 64'h12345678);
    func = 6'd18; #1;
    chk("flush_lo_kept", {32'd0, mf_data}, 64'hCAFEF00D);
    valid = 1'b0;
    step();

    valid = 1'b1; func = 6'd25; op_a = 32'hFFFF0000; op_b = 32'd3;
    step();
    repeat (19) step();
    chk("rst_busy20", {63'd0, md_busy}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_stall", {63'd0, stall}, 64'd0);
    chk("rst_async_busy", {63'd0, md_busy}, 64'd0);
    chk("rst_async_mf", {32'd0, mf_data}, 64'd0);
    #2;
    reset_n = 1'b1; valid = 1'b0;
    step();
    step();
    chk("rst_no_resume", {63'd0, md_busy}, 64'd0);
    valid = 1'b1; func = 6'd16; #1;
    chk("rst_hi_zero", {32'd0, mf_data}, 64'd0);
    func = 6'd18; #1;
    chk("rst_lo_zero", {32'd0, mf_data}, 64'd0);

    func = 6'd17; op_a = 32'h000000AA; flush = 1'b1;
    step();
    flush = 1'b0; func = 6'd16; #1;
    chk("flush_blocks_mthi", {32'd0, mf_data}, 64'd0);
    alu_op = 2'd0; #1;
    chk("mf_other_aluop", {32'd0, mf_data}, 64'd0);
    valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
